// File: rtl/calr_pkg.sv
// -----------------------------------------------------------------------------
// calr_pkg
// Shared definitions for the coeff_abs_level_remaining binarizer:
//   - calr_state_t    : bin sequencer states
//   - CALR_PREFIX_MAX : number of unary prefix ones before escaping to Exp-Golomb
//   - calr_clamp_k    : limits the Rice parameter to the largest legal value
// -----------------------------------------------------------------------------
package calr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFIX    = 3'd1,
    ST_RICE_SUF  = 3'd2,
    ST_EG_PREFIX = 3'd3,
    ST_EG_SUF    = 3'd4
  } calr_state_t;

  localparam int unsigned CALR_PREFIX_MAX = 4;

  // Saturate the Rice parameter at max_k.
  function automatic logic [3:0] calr_clamp_k(input logic [3:0] k, input logic [3:0] max_k);
    logic [3:0] res;
    if (k > max_k) begin
      res = max_k;
    end else begin
      res = k;
    end
    return res;
  endfunction

endpackage

// File: rtl/calr_egk_gen.sv
// -----------------------------------------------------------------------------
// calr_egk_gen
// Exp-Golomb bin sequencer used for the escape part of the code.
// Loaded with the remainder v and start order j when a symbol is captured; the
// parent then steps it once per accepted bin.
//   clk, rst     : clock, asynchronous active-high reset
//   load         : capture load_v / load_j (symbol capture)
//   load_v       : remainder to code
//   load_j       : starting order (k+1)
//   in_suf       : parent is in the suffix phase (0 = prefix phase)
//   adv          : current bin accepted, step to next bin
//   eg_bin       : current bin value
//   eg_pre_end   : current bin is the terminating 0 of the prefix
//   eg_suf_last  : current bin is the last suffix bin
// -----------------------------------------------------------------------------
module calr_egk_gen #(
  parameter int AW = 22,
  parameter int JW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_v,
  input  logic [JW-1:0] load_j,
  input  logic          in_suf,
  input  logic          adv,
  output logic          eg_bin,
  output logic          eg_pre_end,
  output logic          eg_suf_last
);

  logic [AW-1:0] v_r;
  logic [JW-1:0] j_r;
  logic [JW-1:0] idx_r;
  logic [AW-1:0] pow_s;
  logic          ge_s;

  // Current bin decode: prefix emits 1 while v >= 2^j, suffix emits v MSB first.
  always_comb begin
    pow_s       = {{(AW-1){1'b0}}, 1'b1} << j_r;
    ge_s        = (v_r >= pow_s);
    eg_pre_end  = ~ge_s & ~in_suf;
    eg_suf_last = in_suf & (idx_r == {JW{1'b0}});
    if (in_suf) begin
      eg_bin = v_r[idx_r];
    end else begin
      eg_bin = ge_s;
    end
  end

  // Remainder / order / suffix index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r   <= {AW{1'b0}};
      j_r   <= {JW{1'b0}};
      idx_r <= {JW{1'b0}};
    end else if (load) begin
      v_r   <= load_v;
      j_r   <= load_j;
      idx_r <= {JW{1'b0}};
    end else if (adv) begin
      if (in_suf) begin
        idx_r <= idx_r - {{(JW-1){1'b0}}, 1'b1};
      end else if (ge_s) begin
        v_r <= v_r - pow_s;
        j_r <= j_r + {{(JW-1){1'b0}}, 1'b1};
      end else begin
        // Prefix terminator accepted: suffix carries j bits, MSB first.
        idx_r <= j_r - {{(JW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/calr_bin_stream.sv
// -----------------------------------------------------------------------------
// calr_bin_stream
// Binarizes coeff_abs_level_remaining into a bin stream: a truncated unary
// prefix (up to CALR_PREFIX_MAX ones) followed either by a k-bit Rice suffix or,
// for large values, an Exp-Golomb order k+1 escape. One bin per cycle with a
// valid/ready handshake on both sides.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : symbol offered
//   in_ready      : block idle and able to accept a symbol
//   calr_value    : coeff_abs_level_remaining value
//   c_rice_param  : Rice parameter k (clamped to MAX_RICE)
//   bin_valid     : bin presented
//   bin_ready     : downstream accepts bin
//   bin           : current bin value
//   bin_last      : current bin is final bin of the symbol
// Optional (macro CALR_PACKED_OUT_EN):
//   bin_string    : accumulated bins, first bin in MSB of the used field
//   bin_length    : number of bins in bin_string
//   done          : one-cycle pulse after the last bin is accepted
// -----------------------------------------------------------------------------
module calr_bin_stream
  import calr_pkg::*;
#(
  parameter int VALUE_WIDTH = 16,
  parameter int MAX_RICE    = 4,
  parameter int MAX_BINS    = 2*VALUE_WIDTH+8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VALUE_WIDTH-1:0] calr_value,
  input  logic [3:0]             c_rice_param,
  output logic                   bin_valid,
  input  logic                   bin_ready,
  output logic                   bin,
  output logic                   bin_last
`ifdef CALR_PACKED_OUT_EN
  ,
  output logic [MAX_BINS-1:0]            bin_string,
  output logic [$clog2(MAX_BINS+1)-1:0]  bin_length,
  output logic                           done
`endif
);

  localparam int AW = VALUE_WIDTH + MAX_RICE + 2;
  localparam int JW = $clog2(AW + 1);

  calr_state_t   state_r, state_s;
  logic [AW-1:0] value_r;
  logic [3:0]    k_r;
  logic [3:0]    cnt_r, cnt_s;

  logic [3:0]    k_in_s;
  logic [AW-1:0] value_in_s;
  logic [AW-1:0] eg_v_s;
  logic [JW-1:0] eg_j_s;
  logic [AW-1:0] q_s;
  logic          q_small_s;
  logic          pre_end_s;
  logic          capture_s;
  logic          hs_s;
  logic          eg_bin_s;
  logic          eg_pre_end_s;
  logic          eg_suf_last_s;

  // Input-side derived values: clamped k, escape remainder and start order.
  always_comb begin
    k_in_s     = calr_clamp_k(c_rice_param, 4'(MAX_RICE));
    value_in_s = {{(AW-VALUE_WIDTH){1'b0}}, calr_value};
    // Only consumed when value >> k >= CALR_PREFIX_MAX, so never underflows there.
    eg_v_s     = value_in_s - (AW'(CALR_PREFIX_MAX) << k_in_s);
    eg_j_s     = JW'(k_in_s) + {{(JW-1){1'b0}}, 1'b1};
    in_ready   = (state_r == ST_IDLE) & ~rst;
    capture_s  = in_valid & in_ready;
    hs_s       = bin_valid & bin_ready;
    q_s        = value_r >> k_r;
    q_small_s  = (q_s < AW'(CALR_PREFIX_MAX));
  end

  // Next-state and bin output decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bin_valid = 1'b0;
    bin       = 1'b0;
    bin_last  = 1'b0;
    pre_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          state_s = ST_PREFIX;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREFIX: begin
        bin_valid = 1'b1;
        if (q_small_s) begin
          // q ones then a terminating zero.
          bin       = (cnt_r < q_s[3:0]);
          pre_end_s = (cnt_r == q_s[3:0]);
        end else begin
          bin       = 1'b1;
          pre_end_s = (cnt_r == 4'(CALR_PREFIX_MAX - 1));
        end
        bin_last = pre_end_s & q_small_s & (k_r == 4'd0);
        if (hs_s) begin
          if (pre_end_s) begin
            if (!q_small_s) begin
              state_s = ST_EG_PREFIX;
            end else if (k_r == 4'd0) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RICE_SUF;
              cnt_s   = k_r - 4'd1;
            end
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end else begin
          state_s = ST_PREFIX;
        end
      end
      ST_RICE_SUF: begin
        bin_valid = 1'b1;
        bin       = value_r[cnt_r];
        bin_last  = (cnt_r == 4'd0);
        if (hs_s) begin
          if (bin_last) begin
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r - 4'd1;
          end
        end else begin
          state_s = ST_RICE_SUF;
        end
      end
      ST_EG_PREFIX: begin
        bin_valid = 1'b1;
        bin       = eg_bin_s;
        if (hs_s && eg_pre_end_s) begin
          state_s = ST_EG_SUF;
        end else begin
          state_s = ST_EG_PREFIX;
        end
      end
      ST_EG_SUF: begin
        bin_valid = 1'b1;
        bin       = eg_bin_s;
        bin_last  = eg_suf_last_s;
        if (hs_s && eg_suf_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_EG_SUF;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, symbol and bin counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      value_r <= {AW{1'b0}};
      k_r     <= 4'd0;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (capture_s) begin
        value_r <= value_in_s;
        k_r     <= k_in_s;
      end
    end
  end

  calr_egk_gen #(
    .AW (AW),
    .JW (JW)
  ) u_egk (
    .clk         (clk),
    .rst         (rst),
    .load        (capture_s),
    .load_v      (eg_v_s),
    .load_j      (eg_j_s),
    .in_suf      (state_r == ST_EG_SUF),
    .adv         (hs_s & ((state_r == ST_EG_PREFIX) | (state_r == ST_EG_SUF))),
    .eg_bin      (eg_bin_s),
    .eg_pre_end  (eg_pre_end_s),
    .eg_suf_last (eg_suf_last_s)
  );

`ifdef CALR_PACKED_OUT_EN
  localparam int LW = $clog2(MAX_BINS + 1);

  // Packed copy of the symbol: shifted in per accepted bin, cleared on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_string <= {MAX_BINS{1'b0}};
      bin_length <= {LW{1'b0}};
      done       <= 1'b0;
    end else if (capture_s) begin
      bin_string <= {MAX_BINS{1'b0}};
      bin_length <= {LW{1'b0}};
      done       <= 1'b0;
    end else begin
      done <= hs_s & bin_last;
      if (hs_s) begin
        bin_string <= {bin_string[MAX_BINS-2:0], bin};
        bin_length <= bin_length + {{(LW-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_calr_bin_stream.sv
// -----------------------------------------------------------------------------
// tb_calr_bin_stream
// Self-checking bench for calr_bin_stream: directed vector table, a 0..77 sweep
// and randomized symbols with random bin_ready throttling, all against a
// reference binarizer written directly from the coding rules, plus reset
// corner sequences.
// -----------------------------------------------------------------------------
module tb_calr_bin_stream;

  localparam int VW       = 16;
  localparam int MRICE    = 4;
  localparam int MBINS    = 2*VW+8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] calr_value;
  logic [3:0]    c_rice_param;
  logic          bin_valid;
  logic          bin_ready;
  logic          bin;
  logic          bin_last;
`ifdef CALR_PACKED_OUT_EN
  logic [MBINS-1:0]            bin_string;
  logic [$clog2(MBINS+1)-1:0]  bin_length;
  logic                        done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  calr_bin_stream #(
    .VALUE_WIDTH (VW),
    .MAX_RICE    (MRICE),
    .MAX_BINS    (MBINS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .calr_value   (calr_value),
    .c_rice_param (c_rice_param),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .bin          (bin),
    .bin_last     (bin_last)
`ifdef CALR_PACKED_OUT_EN
    ,
    .bin_string   (bin_string),
    .bin_length   (bin_length),
    .done         (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference binarizer: bins packed with the first bin in the MSB of the used field.
  function automatic void model(input int unsigned value, input int unsigned kin,
                                output logic [63:0] pat, output int n);
    int unsigned     k;
    longint unsigned q, v;
    int              j;
    k   = (kin > MRICE) ? MRICE : kin;
    pat = 64'd0;
    n   = 0;
    q   = value >> k;
    if (q < 4) begin
      for (int i = 0; i < int'(q); i++) begin pat = {pat[62:0], 1'b1}; n++; end
      pat = {pat[62:0], 1'b0}; n++;
      for (int b = int'(k) - 1; b >= 0; b--) begin pat = {pat[62:0], value[b]}; n++; end
    end else begin
      for (int i = 0; i < 4; i++) begin pat = {pat[62:0], 1'b1}; n++; end
      v = longint'(value) - (longint'(4) << k);
      j = int'(k) + 1;
      while (v >= (64'd1 << j)) begin
        pat = {pat[62:0], 1'b1}; n++;
        v   = v - (64'd1 << j);
        j++;
      end
      pat = {pat[62:0], 1'b0}; n++;
      for (int b = j - 1; b >= 0; b--) begin pat = {pat[62:0], v[b]}; n++; end
    end
  endfunction

  // Offer one symbol and collect its bins. mode 0: bin_ready held high, mode 1: random.
  task automatic run_symbol(input int value, input int k, input int mode,
                            output logic [63:0] pat, output int n);
    int   t;
    int   cyc;
    int   bubbles;
    bit   fin;
    bit   stall_prev;
    logic [2:0] held;
    pat = 64'd0;
    n   = 0;
    t   = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid     = 1'b1;
    calr_value   = VW'(value);
    c_rice_param = 4'(k);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_bin_latency", {62'd0, bin_valid, in_ready}, 64'd2);
    fin = 1'b0; cyc = 0; bubbles = 0; stall_prev = 1'b0; held = 3'd0;
    while (!fin && cyc < 300) begin
      bin_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stall_prev) chk("stall_hold", {61'd0, bin_valid, bin, bin_last}, {61'd0, held});
      if (!bin_valid) bubbles++;
      if (bin_valid && bin_ready) begin
        pat = {pat[62:0], bin};
        n++;
        if (bin_last) fin = 1'b1;
      end
      stall_prev = bin_valid & ~bin_ready;
      held       = {bin_valid, bin, bin_last};
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) chk("bin_timeout", 64'd0, 64'd1);
    chk("idle_after_last", {62'd0, in_ready, bin_valid}, 64'd2);
    if (mode == 0) chk("bubbles", 64'(bubbles), 64'd0);
`ifdef CALR_PACKED_OUT_EN
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("bin_length", 64'(bin_length), 64'(n));
    chk("bin_string", 64'(bin_string), pat);
`endif
  endtask

  typedef struct {
    int          value;
    int          k;
    int          n;
    logic [63:0] pat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [63:0] got_pat, exp_pat;
    int          got_n, exp_n, cnt;
    int          val, kk;

    tbl[0] = '{0,  0, 1,  64'h0};
    tbl[1] = '{3,  0, 4,  64'hE};
    tbl[2] = '{4,  0, 6,  64'h3C};
    tbl[3] = '{5,  1, 4,  64'hD};
    tbl[4] = '{77, 9, 10, 64'h3CD};
    tbl[5] = '{5,  9, 5,  64'h05};
    tbl[6] = '{77, 0, 16, 64'hFF8B};
    tbl[7] = '{10, 2, 5,  64'h1A};
    tbl[8] = '{2,  0, 3,  64'h6};
    tbl[9] = '{40, 3, 9,  64'h1E8};

    rst = 1'b1; in_valid = 1'b0; bin_ready = 1'b0; calr_value = '0; c_rice_param = 4'd0;
    #3;
    chk("reset_outputs", {60'd0, in_ready, bin_valid, bin, bin_last}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_symbol(tbl[i].value, tbl[i].k, 0, got_pat, got_n);
      chk($sformatf("tbl%0d_len", i), 64'(got_n), 64'(tbl[i].n));
      chk($sformatf("tbl%0d_bins", i), got_pat, tbl[i].pat);
    end

    // Sweep 0..77 with k = 0.
    for (int v = 0; v <= 77; v++) begin
      run_symbol(v, 0, 0, got_pat, got_n);
      model(v, 0, exp_pat, exp_n);
      chk($sformatf("sweep%0d_len", v), 64'(got_n), 64'(exp_n));
      chk($sformatf("sweep%0d_bins", v), got_pat, exp_pat);
    end

    // Randomized symbols with random downstream throttling.
    for (int i = 0; i < 60; i++) begin
      val = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 65535));
      kk  = int'($urandom_range(0, 15));
      run_symbol(val, kk, 1, got_pat, got_n);
      model(val, kk, exp_pat, exp_n);
      chk($sformatf("rand%0d_len", i), 64'(got_n), 64'(exp_n));
      chk($sformatf("rand%0d_bins", i), got_pat, exp_pat);
    end

    // Reset while bin 3 of value 77 is presented.
    bin_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; calr_value = VW'(77); c_rice_param = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_symbol_bin3", {62'd0, bin_valid, bin}, 64'd3);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {60'd0, in_ready, bin_valid, bin, bin_last}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bin_valid) cnt++;
    end
    chk("no_bins_after_rst", 64'(cnt), 64'd0);
    chk("in_ready_after_mid_rst", {63'd0, in_ready}, 64'd1);
    run_symbol(4, 0, 0, got_pat, got_n);
    chk("post_rst_len", 64'(got_n), 64'd6);
    chk("post_rst_bins", got_pat, 64'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calr_bin_stream.md
CALR_BIN_STREAM -- requirements
Module: calr_bin_stream

Interface
REQ-001 Parameter VALUE_WIDTH, default 16: width of coeff_abs_level_remaining input.
REQ-002 Parameter MAX_RICE, default 4: largest legal cRiceParam.
REQ-003 Parameter MAX_BINS, default 2*VALUE_WIDTH+8: worst-case bin count per symbol.
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port in_valid  in  1  symbol offered.
REQ-007 Port in_ready  out  1  block can accept a symbol.
REQ-008 Port calr_value  in  VALUE_WIDTH  coeff_abs_level_remaining value.
REQ-009 Port c_rice_param  in  4  Rice parameter k.
REQ-010 Port bin_valid  out  1  bin presented.
REQ-011 Port bin_ready  in  1  downstream accepts bin.
REQ-012 Port bin  out  1  current bin value.
REQ-013 Port bin_last  out  1  current bin is final bin of symbol.

Function
REQ-014 Symbol SHALL be captured on the cycle in_valid && in_ready; k SHALL be clamped to MAX_RICE when c_rice_param > MAX_RICE.
REQ-015 in_ready SHALL be 1 only in state IDLE; first bin SHALL have bin_valid=1 the cycle after capture.
REQ-016 A bin SHALL advance only on bin_valid && bin_ready; bin, bin_last, bin_valid SHALL hold stable while bin_ready=0.
REQ-017 States: IDLE -> PREFIX -> (RICE_SUF | EG_PREFIX -> EG_SUF) -> IDLE; zero-length suffix states SHALL be skipped with no bubble.
REQ-018 With q = value >> k and q < 4: PREFIX SHALL emit q ones then one zero; RICE_SUF SHALL emit k LSBs of value, MSB first.
REQ-019 With q >= 4: PREFIX SHALL emit "1111"; then v = value - (4 << k) SHALL be coded Exp-Golomb order k+1: EG_PREFIX emits one 1 per step while v >= 2^j (v -= 2^j, j++), then a 0; EG_SUF emits j LSBs of v, MSB first.
REQ-020 Arithmetic SHALL use VALUE_WIDTH+MAX_RICE+2 bits internally; no overflow for any input.
REQ-021 Sustained throughput SHALL be 1 bin/cycle with bin_ready=1; one idle cycle (in_ready=1) between symbols.
REQ-022 After bin_last handshake, block SHALL return to IDLE next cycle.

Reset
REQ-023 rst=1 SHALL at once force IDLE, bin_valid=0, bin=0, bin_last=0, in_ready=0 while asserted; in_ready=1 first cycle after release.
REQ-024 rst mid-symbol SHALL discard the symbol; no partial bins after release.

Configuration
REQ-025 Macro CALR_PACKED_OUT_EN defined: extra outputs bin_string [MAX_BINS-1:0] (first bin in MSB of used field, right-aligned), bin_length [$clog2(MAX_BINS+1)-1:0], done (1-cycle pulse with bin_last handshake); values held until next capture, reset to 0.
REQ-026 Macro undefined: those ports and their logic SHALL not exist; streaming behaviour identical.

Structure
REQ-027 Package calr_pkg SHALL hold state enum calr_state_t, constant CALR_PREFIX_MAX = 4, clamp function for k.
REQ-028 Sub-module calr_egk_gen (Exp-Golomb order-j bin sequencer) SHALL implement EG_PREFIX/EG_SUF stepping.

Verification
REQ-029 k=0, value 0 -> 1 bin "0", bin_last on it.
REQ-030 k=0, values 3 and 4 -> "1110" (4 bins); "111100" (6 bins).
REQ-031 k=1, value 5 -> "1101"; c_rice_param=9 with MAX_RICE=4 -> coded as k=4.
REQ-032 k=0, value 77 -> "1111111110001011" (16 bins); sweep 0..77 matches software model.
REQ-033 Random bin_ready throttling -> bins stable while stalled, sequence unchanged; rst at bin 3 of value 77 -> no bins after release, next symbol correct.
REQ-034 With CALR_PACKED_OUT_EN, value 77 k=0 -> bin_length=16, bin_string[15:0]=16'hFF8B, done pulsed once.
